ceas_alarme_multi: RTL
======================

// Module: ceas_alarme_multi
// PURPOSE
//  Parametrised time-of-day core with N independent alarm channels: 1 s prescaler, hh:mm:ss counter,
//  alarm register bank, ringing state machine with auto-timeout. Replaces the bare counter+load path
//  inside the clock top; fed by the setting block (ore/minute + load strobes), drives display and led.
// PARAMETERS
//  CLK_HZ       50_000_000  clock cycles per second tick (>=2)
//  N_ALARME     2           number of alarm channels, 1..8
//  ALARM_LEN_S  60          seconds led stays on if not stopped (>=1)
//  SNOOZE_MIN   5           snooze duration in minutes (used only with ALARM_SNOOZE_EN)
// PORTS
//  clock          in   1         system clock, all logic on rising edge
//  reset          in   1         asynchronous, active-low; clears all state
//  load_timp      in   1         1-cycle strobe: load ore_in/minute_in as current time
//  load_alarma    in   1         1-cycle strobe: write alarm channel alarma_idx
//  ore_in         in   5         hours for load, valid 0..23
//  minute_in      in   6         minutes for load, valid 0..59
//  alarma_idx     in   3         alarm channel for load_alarma
//  alarma_en_in   in   1         enable bit written with the alarm
//  semnal_stop    in   1         level, sampled each cycle: silence alarm
//  semnal_snooze  in   1         level, sampled each cycle: snooze (ignored without macro)
//  ore            out  5         current hours
//  minute         out  6         current minutes
//  secunde        out  6         current seconds
//  tick_sec       out  1         1-cycle pulse per second
//  load_err       out  1         1-cycle pulse: rejected load (range or index)
//  led            out  1         alarm ringing indicator
//  alarma_activa  out  N_ALARME  channels that caused current ringing
// BEHAVIOUR
//  Reset: time 00:00:00, prescaler 0, all alarms 00:00 disabled, state IDLE, every output 0.
//  Prescaler counts 0..CLK_HZ-1; tick_sec=1 in the cycle after the count was CLK_HZ-1 (registered).
//  On tick: sec+1; 59->0 with min+1; min 59->0 with hour+1; hour 23->0. All registered, same edge.
//  load_timp (valid): next edge ore/minute <= inputs, secunde <= 0, prescaler <= 0, no tick that cycle.
//  load_timp beats a coincident tick. ore_in>23 or minute_in>59: no change, load_err=1 next cycle.
//  load_alarma: alarm[idx] <= {ore_in, minute_in, alarma_en_in}; idx>=N_ALARME or range error -> ignored,
//  load_err=1. load_timp and load_alarma same cycle: both applied (each checked independently).
//  Match: on a tick whose result is secunde==0, every enabled channel whose hh:mm equals the new time
//  fires. load_timp never causes a match (loading 07:30 does not ring a 07:30 alarm).
//  FSM: IDLE -> SUNA on any fire: led=1, alarma_activa=fired bits, len counter=ALARM_LEN_S.
//   SUNA: each tick len-1; len reaches 0 -> IDLE. semnal_stop -> IDLE next cycle.
//   Fire while in SUNA: OR new bits into alarma_activa, len reloaded.
//   Fire and semnal_stop same cycle: fire wins; alarma_activa = new bits only, len reloaded.
//   IDLE/SNOOZE outputs: led=0; alarma_activa=0 in IDLE, held in SNOOZE.
//  Alarm writes during SUNA do not affect ringing; disabling a fired channel does not stop it.
//  reset asserted mid-ring: immediate IDLE, led=0, alarms lost.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined: SUNA + semnal_snooze -> SNOOZE, led=0, counter=SNOOZE_MIN*60 ticks; expiry
//   -> SUNA, same alarma_activa, len reloaded. stop in SNOOZE -> IDLE. New fire in SNOOZE -> SUNA, OR bits.
//  Not defined: no SNOOZE state, semnal_snooze ignored (port kept), SUNA exits only by stop/timeout.
// TESTING  (CLK_HZ=4, N_ALARME=2, ALARM_LEN_S=3, SNOOZE_MIN=1)
//  1. Release reset, run 240 cycles -> tick_sec every 4th cycle, 00:01:00 after 60 ticks.
//  2. load_timp 23:59, 60 ticks -> 00:00:00 at the 60th tick, load_err stays 0.
//  3. alarm0=07:30 en, load 07:29, 60 ticks -> led=1, alarma_activa=01 at 07:30:00; led=0 after 3 ticks.
//  4. Ringing + semnal_stop 1 cycle -> led=0 next cycle; load_timp ore_in=24 -> load_err pulse, time kept.
//  5. alarm0=alarm1=08:00 en, alarma_idx=2 write -> load_err; at 08:00:00 alarma_activa=11.
//  6. ALARM_SNOOZE_EN: ringing + snooze -> led=0, 60 ticks later led=1, alarma_activa unchanged.

Source files
------------

// File: rtl/ceas_alarme_multi.sv
// Time-of-day core with N_ALARME alarm channels and a ringing state machine with auto-timeout.
// Define ALARM_SNOOZE_EN to add the SNOOZE state driven by semnal_snooze.
module ceas_alarme_multi #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_ALARME    = 2,
  parameter int ALARM_LEN_S = 60,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_timp,
  input  logic                load_alarma,
  input  logic [4:0]          ore_in,
  input  logic [5:0]          minute_in,
  input  logic [2:0]          alarma_idx,
  input  logic                alarma_en_in,
  input  logic                semnal_stop,
  input  logic                semnal_snooze,
  output logic [4:0]          ore,
  output logic [5:0]          minute,
  output logic [5:0]          secunde,
  output logic                tick_sec,
  output logic                load_err,
  output logic                led,
  output logic [N_ALARME-1:0] alarma_activa
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
`ifdef ALARM_SNOOZE_EN
  localparam int CMAX = (SNOOZE_MIN * 60 > ALARM_LEN_S) ? SNOOZE_MIN * 60 : ALARM_LEN_S;
`else
  localparam int CMAX = ALARM_LEN_S;
`endif
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LEN_LOAD = CW'(ALARM_LEN_S);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    N_LIM    = 4'(N_ALARME);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SUNA = 2'd1, SNOOZE = 2'd2} state_t;
  localparam logic [CW-1:0] SNZ_LOAD = CW'(SNOOZE_MIN * 60);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SUNA = 2'd1} state_t;
  logic unused_snooze_s;
  assign unused_snooze_s = semnal_snooze;
`endif

  logic [PW-1:0]       presc_r;
  logic [4:0]          ore_r;
  logic [5:0]          min_r;
  logic [5:0]          sec_r;
  logic                tick_r;
  logic                load_err_r;
  logic [4:0]          al_h_r [N_ALARME];
  logic [5:0]          al_m_r [N_ALARME];
  logic [N_ALARME-1:0] al_en_r;
  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic                led_r;
  logic [N_ALARME-1:0] act_r;

  logic                time_ok_s;
  logic                alarm_ok_s;
  logic                tick_s;
  logic                wrap_s;
  logic [4:0]          ore_nx_s;
  logic [5:0]          min_nx_s;
  logic [5:0]          sec_nx_s;
  logic [N_ALARME-1:0] fire_s;

  // Load validation and next time-of-day; a valid time load swallows a coincident tick.
  always_comb begin
    time_ok_s  = (ore_in <= 5'd23) && (minute_in <= 6'd59);
    alarm_ok_s = time_ok_s && ({1'b0, alarma_idx} < N_LIM);
    tick_s     = (presc_r == PRESC_MAX) && !(load_timp && time_ok_s);
    wrap_s     = tick_s && (sec_r == 6'd59);
    sec_nx_s   = sec_r;
    min_nx_s   = min_r;
    ore_nx_s   = ore_r;
    if (tick_s) begin
      if (sec_r == 6'd59) begin
        sec_nx_s = 6'd0;
        if (min_r == 6'd59) begin
          min_nx_s = 6'd0;
          ore_nx_s = (ore_r == 5'd23) ? 5'd0 : ore_r + 5'd1;
        end else begin
          min_nx_s = min_r + 6'd1;
        end
      end else begin
        sec_nx_s = sec_r + 6'd1;
      end
    end else begin
      sec_nx_s = sec_r;
    end
  end

  // Channels fire only when a tick rolls the seconds over to 0 on their hh:mm.
  always_comb begin
    fire_s = '0;
    for (int i = 0; i < N_ALARME; i++) begin
      fire_s[i] = wrap_s && al_en_r[i] && (al_h_r[i] == ore_nx_s) && (al_m_r[i] == min_nx_s);
    end
  end

  // Prescaler, time-of-day registers and the one-cycle strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_r    <= '0;
      ore_r      <= 5'd0;
      min_r      <= 6'd0;
      sec_r      <= 6'd0;
      tick_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      load_err_r <= (load_timp && !time_ok_s) || (load_alarma && !alarm_ok_s);
      if (load_timp && time_ok_s) begin
        presc_r <= '0;
        ore_r   <= ore_in;
        min_r   <= minute_in;
        sec_r   <= 6'd0;
        tick_r  <= 1'b0;
      end else begin
        presc_r <= (presc_r == PRESC_MAX) ? '0 : presc_r + PRESC_ONE;
        ore_r   <= ore_nx_s;
        min_r   <= min_nx_s;
        sec_r   <= sec_nx_s;
        tick_r  <= tick_s;
      end
    end
  end

  // Alarm register bank; out-of-range writes are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ALARME; i++) begin
        al_h_r[i] <= 5'd0;
        al_m_r[i] <= 6'd0;
      end
      al_en_r <= '0;
    end else if (load_alarma && alarm_ok_s) begin
      for (int i = 0; i < N_ALARME; i++) begin
        if (alarma_idx == 3'(i)) begin
          al_h_r[i]  <= ore_in;
          al_m_r[i]  <= minute_in;
          al_en_r[i] <= alarma_en_in;
        end
      end
    end
  end

  // Ringing FSM: a new fire always wins over stop, and stop over snooze or timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      led_r   <= 1'b0;
      act_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|fire_s) begin
            state_r <= SUNA;
            led_r   <= 1'b1;
            act_r   <= fire_s;
            cnt_r   <= LEN_LOAD;
          end
        end
        SUNA: begin
          if (|fire_s) begin
            act_r <= semnal_stop ? fire_s : (act_r | fire_s);
            cnt_r <= LEN_LOAD;
          end else if (semnal_stop) begin
            state_r <= IDLE;
            led_r   <= 1'b0;
            act_r   <= '0;
`ifdef ALARM_SNOOZE_EN
          end else if (semnal_snooze) begin
            state_r <= SNOOZE;
            led_r   <= 1'b0;
            cnt_r   <= SNZ_LOAD;
`endif
          end else if (tick_s) begin
            if (cnt_r == CNT_ONE) begin
              state_r <= IDLE;
              led_r   <= 1'b0;
              act_r   <= '0;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (|fire_s) begin
            state_r <= SUNA;
            led_r   <= 1'b1;
            act_r   <= semnal_stop ? fire_s : (act_r | fire_s);
            cnt_r   <= LEN_LOAD;
          end else if (semnal_stop) begin
            state_r <= IDLE;
            act_r   <= '0;
          end else if (tick_s) begin
            if (cnt_r == CNT_ONE) begin
              state_r <= SUNA;
              led_r   <= 1'b1;
              cnt_r   <= LEN_LOAD;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          led_r   <= 1'b0;
          act_r   <= '0;
        end
      endcase
    end
  end

  assign ore           = ore_r;
  assign minute        = min_r;
  assign secunde       = sec_r;
  assign tick_sec      = tick_r;
  assign load_err      = load_err_r;
  assign led           = led_r;
  assign alarma_activa = act_r;

endmodule
